// File: rtl/rh_multi_wc_if.sv
// rh_multi_wc_if: register-decode side bus of the multi-channel RH11 word-count block.
// The master side is the register decode / DMA sequencer environment; the
// slave side is rh_multi_wc. devDATAI keeps the device's big-endian numbering.
interface rh_multi_wc_if #(
   parameter int NCH   = 4,
   parameter int WIDTH = 16,
   parameter int SELW  = 2
);
   logic                    devRESET;
   logic [WIDTH/8-1:0]      devBYTE;
   logic [0:35]             devDATAI;
   logic [SELW-1:0]         wcSEL;
   logic                    wcWRITE;
   logic [NCH-1:0]          wcCLR;
   logic [NCH-1:0]          rhINC;
   logic [SELW-1:0]         rdSEL;
   logic [WIDTH+1:0]        rdDATA;
   logic [NCH*WIDTH-1:0]    wcOUT;
   logic [NCH-1:0]          wcZERO;
   logic [NCH-1:0]          wcOVF;
   logic [NCH-1:0]          wcDONE;

   modport master (
      output devRESET, devBYTE, devDATAI, wcSEL, wcWRITE, wcCLR, rhINC, rdSEL,
      input  rdDATA, wcOUT, wcZERO, wcOVF, wcDONE
   );

   modport slave (
      input  devRESET, devBYTE, devDATAI, wcSEL, wcWRITE, wcCLR, rhINC, rdSEL,
      output rdDATA, wcOUT, wcZERO, wcOVF, wcDONE
   );
endinterface

// File: rtl/rh_multi_wc.sv
// rh_multi_wc: NCH independent RH11 transfer word-count counters.
// Each channel counts up by STEP from a software-loaded negative count, with
// sticky ZERO (terminal count) and OVF flags and a one-cycle done pulse.
// Optional build macro RH_WC_SATURATE_EN: an increment on a channel that has
// already reached terminal count holds the counter at 0 instead of wrapping
// to STEP. Without the macro the counter wraps to STEP.
module rh_multi_wc #(
   parameter int NCH   = 4,
   parameter int WIDTH = 16,
   parameter int STEP  = 2,
   parameter int SELW  = 2
) (
   input  logic             clk,
   input  logic             rst,
   rh_multi_wc_if.slave     bus
);
   localparam int              NB    = WIDTH / 8;
   localparam logic [WIDTH:0]  STEPV = (WIDTH + 1)'(STEP);
   localparam logic [SELW:0]   NCHV  = (SELW + 1)'(NCH);

   // Per-channel state
   logic [WIDTH-1:0] wcReg   [NCH];
   logic             zeroReg [NCH];
   logic             ovfReg  [NCH];
   logic             doneReg [NCH];
   logic [WIDTH+1:0] rdReg;

   // Little-endian view of the device data (device bit 35 is the LSB)
   logic [WIDTH-1:0] dataLe;
   logic             unusedData;

   // Bit-swap the big-endian device word into counter bit order
   always_comb begin
      dataLe = '0;
      for (int i = 0; i < WIDTH; i++) begin
         dataLe[i] = bus.devDATAI[35 - i];
      end
   end

   // Device bits above the counter width never reach a counter
   assign unusedData = ^bus.devDATAI[0:35-WIDTH];

   for (genvar gi = 0; gi < NCH; gi++) begin : gChan
      logic             hitWrite;
      logic [WIDTH-1:0] writeVal;
      logic [WIDTH:0]   sumInc;

      // wcSEL values at or above NCH never match any channel
      assign hitWrite = bus.wcWRITE && (bus.wcSEL == SELW'(gi));
      assign sumInc   = {1'b0, wcReg[gi]} + STEPV;

      // Merge enabled byte lanes of the write data into the current count
      always_comb begin
         writeVal = wcReg[gi];
         for (int b = 0; b < NB; b++) begin
            if (bus.devBYTE[b]) begin
               writeVal[8*b +: 8] = dataLe[8*b +: 8];
            end
         end
      end

      // Channel update: reset > devRESET > clear > write > increment
      always_ff @(posedge clk) begin
         if (rst || bus.devRESET || bus.wcCLR[gi]) begin
            wcReg[gi]   <= '0;
            zeroReg[gi] <= 1'b0;
            ovfReg[gi]  <= 1'b0;
            doneReg[gi] <= 1'b0;
         end else if (hitWrite) begin
            wcReg[gi]   <= writeVal;
            zeroReg[gi] <= 1'b0;
            ovfReg[gi]  <= 1'b0;
            doneReg[gi] <= 1'b0;
         end else if (bus.rhINC[gi]) begin
            doneReg[gi] <= 1'b0;
            if (zeroReg[gi]) begin
               // Counting past terminal count is an overrun
               ovfReg[gi] <= 1'b1;
`ifdef RH_WC_SATURATE_EN
               wcReg[gi]  <= '0;
`else
               wcReg[gi]  <= STEPV[WIDTH-1:0];
`endif
            end else begin
               wcReg[gi] <= sumInc[WIDTH-1:0];
               if (sumInc[WIDTH-1:0] == '0) begin
                  zeroReg[gi] <= 1'b1;
                  doneReg[gi] <= 1'b1;
               end else if (sumInc[WIDTH]) begin
                  // Step jumped over zero without landing on it
                  ovfReg[gi] <= 1'b1;
               end
            end
         end else begin
            doneReg[gi] <= 1'b0;
         end
      end
   end

   // Registered readback of the selected channel; out-of-range selects read 0
   always_ff @(posedge clk) begin
      if (rst || bus.devRESET) begin
         rdReg <= '0;
      end else if ({1'b0, bus.rdSEL} < NCHV) begin
         rdReg <= {ovfReg[bus.rdSEL], zeroReg[bus.rdSEL], wcReg[bus.rdSEL]};
      end else begin
         rdReg <= '0;
      end
   end

   // Flatten per-channel registers onto the output buses
   always_comb begin
      bus.wcOUT  = '0;
      bus.wcZERO = '0;
      bus.wcOVF  = '0;
      bus.wcDONE = '0;
      for (int n = 0; n < NCH; n++) begin
         bus.wcOUT[n*WIDTH +: WIDTH] = wcReg[n];
         bus.wcZERO[n]               = zeroReg[n];
         bus.wcOVF[n]                = ovfReg[n];
         bus.wcDONE[n]               = doneReg[n];
      end
   end

   assign bus.rdDATA = rdReg;
endmodule

// File: tb/tb_rh_multi_wc.sv
// tb_rh_multi_wc: directed test of rh_multi_wc with a cycle-tagged scoreboard.
// Stimulus pushes hand-computed expectations tagged with the cycle they are
// due; a monitor on the falling edge pops and compares them.
module tb_rh_multi_wc;
   localparam int NCH   = 4;
   localparam int WIDTH = 16;
   localparam int STEP  = 2;
   localparam int SELW  = 2;

`ifdef RH_WC_SATURATE_EN
   localparam logic [15:0] OVR = 16'h0000;
`else
   localparam logic [15:0] OVR = 16'h0002;
`endif

   localparam int K_OUT  = 0;
   localparam int K_ZERO = 1;
   localparam int K_OVF  = 2;
   localparam int K_DONE = 3;
   localparam int K_RD   = 4;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   typedef struct {
      int          due;
      int          kind;
      string       name;
      logic [63:0] exp;
   } item_t;

   item_t sb[$];

   rh_multi_wc_if #(.NCH(NCH), .WIDTH(WIDTH), .SELW(SELW)) bus ();

   rh_multi_wc #(.NCH(NCH), .WIDTH(WIDTH), .STEP(STEP), .SELW(SELW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] sample(input int k);
      case (k)
         K_OUT:   return bus.wcOUT;
         K_ZERO:  return {60'b0, bus.wcZERO};
         K_OVF:   return {60'b0, bus.wcOVF};
         K_DONE:  return {60'b0, bus.wcDONE};
         K_RD:    return {46'b0, bus.rdDATA};
         default: return '1;
      endcase
   endfunction

   // Monitor: compare every expectation due in the current cycle
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            logic [63:0] got;
            got = sample(sb[i].kind);
            tests++;
            if (got !== sb[i].exp) begin
               fails++;
               $display("[TB] FAIL %s cyc=%0d got=%0h expected=%0h",
                        sb[i].name, cyc, got, sb[i].exp);
            end else begin
               $display("[TB] ok   %s cyc=%0d value=%0h", sb[i].name, cyc, got);
            end
            sb.delete(i);
         end
      end
   end

   task automatic pushExp(input int dly, input int kind, input string name,
                          input logic [63:0] v);
      item_t it;
      it.due  = cyc + dly;
      it.kind = kind;
      it.name = name;
      it.exp  = v;
      sb.push_back(it);
   endtask

   task automatic pushAll(input string name, input logic [63:0] o,
                          input logic [3:0] z, input logic [3:0] v,
                          input logic [3:0] d);
      pushExp(1, K_OUT,  {name, "_wc"},   o);
      pushExp(1, K_ZERO, {name, "_zero"}, {60'b0, z});
      pushExp(1, K_OVF,  {name, "_ovf"},  {60'b0, v});
      pushExp(1, K_DONE, {name, "_done"}, {60'b0, d});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.wcWRITE  = 1'b0;
      bus.wcCLR    = '0;
      bus.rhINC    = '0;
      bus.devRESET = 1'b0;
      bus.devBYTE  = '0;
   endtask

   // Upper device bits carry junk that the counter must ignore
   task automatic wr(input logic [1:0] sel, input logic [15:0] d,
                     input logic [1:0] be);
      bus.wcWRITE  = 1'b1;
      bus.wcSEL    = sel;
      bus.devDATAI = {20'hABCDE, d};
      bus.devBYTE  = be;
   endtask

   initial begin
      idle();
      bus.wcSEL    = '0;
      bus.rdSEL    = '0;
      bus.devDATAI = '0;

      // Reset state
      rst = 1'b1;
      pushAll("reset", 64'h0, 4'h0, 4'h0, 4'h0);
      pushExp(1, K_RD, "reset_rd", 64'h0);
      tick();
      tests++;
      if (bus.wcOUT !== 64'h0 || bus.wcZERO !== 4'h0 || bus.wcOVF !== 4'h0) begin
         fails++;
         $display("[TB] FAIL reset_direct out=%0h zero=%0h ovf=%0h",
                  bus.wcOUT, bus.wcZERO, bus.wcOVF);
      end else begin
         $display("[TB] ok   reset_direct out=%0h", bus.wcOUT);
      end
      rst = 1'b0;

      // Write channel 2 and read it back two cycles later
      wr(2'd2, 16'hFFFA, 2'b11);
      bus.rdSEL = 2'd2;
      pushExp(1, K_OUT, "wr2_wc", {16'h0, 16'hFFFA, 16'h0, 16'h0});
      pushExp(1, K_RD,  "wr2_rd_early", 64'h0);
      pushExp(2, K_RD,  "wr2_rd", 64'h0FFFA);
      tick();
      idle();
      tick();

      // Countdown on channel 1
      wr(2'd1, 16'hFFFA, 2'b11);
      pushExp(1, K_OUT, "cd_load", {16'h0, 16'hFFFA, 16'hFFFA, 16'h0});
      tick();
      idle();
      bus.rhINC = 4'b0010;
      pushAll("cd1", {16'h0, 16'hFFFA, 16'hFFFC, 16'h0}, 4'h0, 4'h0, 4'h0);
      tick();
      pushAll("cd2", {16'h0, 16'hFFFA, 16'hFFFE, 16'h0}, 4'h0, 4'h0, 4'h0);
      tick();
      pushAll("cd3", {16'h0, 16'hFFFA, 16'h0000, 16'h0}, 4'h2, 4'h0, 4'h2);
      tick();
      tests++;
      if (bus.wcZERO !== 4'h2 || bus.wcDONE !== 4'h2) begin
         fails++;
         $display("[TB] FAIL cd3_direct zero=%0h done=%0h", bus.wcZERO, bus.wcDONE);
      end else begin
         $display("[TB] ok   cd3_direct zero=%0h done=%0h", bus.wcZERO, bus.wcDONE);
      end
      idle();
      pushExp(1, K_DONE, "cd_after_done", 64'h0);
      tick();

      // Overrun past terminal count
      bus.rdSEL = 2'd1;
      bus.rhINC = 4'b0010;
      pushAll("ovr", {16'h0, 16'hFFFA, OVR, 16'h0}, 4'h2, 4'h2, 4'h0);
      pushExp(2, K_RD, "ovr_rd", {46'b0, 2'b11, OVR});
      tick();
      tests++;
      if (bus.wcOUT[31:16] !== OVR || bus.wcOVF !== 4'h2 || bus.wcDONE !== 4'h0) begin
         fails++;
         $display("[TB] FAIL ovr_direct wc1=%0h ovf=%0h done=%0h",
                  bus.wcOUT[31:16], bus.wcOVF, bus.wcDONE);
      end else begin
         $display("[TB] ok   ovr_direct wc1=%0h ovf=%0h", bus.wcOUT[31:16], bus.wcOVF);
      end
      idle();
      tick();

      // Byte lanes
      wr(2'd0, 16'h1234, 2'b11);
      pushExp(1, K_OUT, "bl_full", {16'h0, 16'hFFFA, OVR, 16'h1234});
      tick();
      wr(2'd0, 16'hAB00, 2'b10);
      pushExp(1, K_OUT, "bl_hi", {16'h0, 16'hFFFA, OVR, 16'hAB34});
      tick();
      wr(2'd1, 16'h5A5A, 2'b00);
      pushAll("bl_none", {16'h0, 16'hFFFA, OVR, 16'hAB34}, 4'h0, 4'h0, 4'h0);
      tick();
      idle();

      // Priority: write beats increment, clear beats write
      wr(2'd3, 16'h0100, 2'b11);
      bus.rhINC = 4'b1000;
      pushExp(1, K_OUT, "pri_wr_inc", {16'h0100, 16'hFFFA, OVR, 16'hAB34});
      tick();
      idle();
      wr(2'd3, 16'h5555, 2'b11);
      bus.wcCLR = 4'b1000;
      pushExp(1, K_OUT, "pri_clr_wr", {16'h0, 16'hFFFA, OVR, 16'hAB34});
      tick();
      idle();

      // devRESET on the cycle a countdown would have hit zero
      wr(2'd2, 16'hFFFC, 2'b11);
      tick();
      idle();
      bus.rhINC = 4'b0100;
      pushExp(1, K_OUT, "dr_cnt", {16'h0, 16'hFFFE, OVR, 16'hAB34});
      tick();
      bus.devRESET = 1'b1;
      pushAll("devreset", 64'h0, 4'h0, 4'h0, 4'h0);
      pushExp(1, K_RD, "devreset_rd", 64'h0);
      tick();
      idle();

      // Parallel terminal count on all channels
      for (int i = 0; i < 4; i++) begin
         wr(2'(i), 16'hFFFE, 2'b11);
         tick();
      end
      idle();
      bus.rhINC = 4'b1111;
      pushAll("par", 64'h0, 4'hF, 4'h0, 4'hF);
      tick();
      tests++;
      if (bus.wcDONE !== 4'hF || bus.wcOUT !== 64'h0) begin
         fails++;
         $display("[TB] FAIL par_direct done=%0h out=%0h", bus.wcDONE, bus.wcOUT);
      end else begin
         $display("[TB] ok   par_direct done=%0h", bus.wcDONE);
      end
      idle();
      pushExp(1, K_DONE, "par_after_done", 64'h0);
      tick();

      // Controller clear of a terminal channel: no done pulse
      bus.wcCLR = 4'b0001;
      pushAll("clr0", 64'h0, 4'hE, 4'h0, 4'h0);
      tick();
      idle();

      // Step overshooting zero sets OVF but not ZERO
      wr(2'd0, 16'hFFFF, 2'b11);
      tick();
      idle();
      bus.rhINC = 4'b0001;
      pushAll("overshoot", {16'h0, 16'h0, 16'h0, 16'h0001}, 4'hE, 4'h1, 4'h0);
      tick();
      idle();

      // Writing zero clears ZERO and does not set it
      wr(2'd3, 16'h0000, 2'b11);
      pushAll("wr_zero", {16'h0, 16'h0, 16'h0, 16'h0001}, 4'h6, 4'h1, 4'h0);
      tick();
      idle();

      repeat (3) tick();
      while (sb.size() > 0) begin
         tests++;
         fails++;
         $display("[TB] FAIL %s never compared due=%0d now=%0d",
                  sb[0].name, sb[0].due, cyc);
         sb.delete(0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
